// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS datapath multicycle multiply/divide unit.
package mips_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } md_state_e;

  typedef enum logic {
    OpMult,
    OpDiv
  } md_op_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next dividend bit,
// subtract the divisor if it fits, and emit the quotient bit.
module div_step
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             next_bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {rem_i, next_bit_i};
  // Extra top bit acts as the borrow flag of the trial subtraction.
  assign diff    = {1'b0, shifted} - {2'b00, divisor_i};
  assign q_bit_o = ~diff[WIDTH+1];
  // rem_i < divisor_i holds every step, so the kept value always fits in WIDTH bits.
  assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring) unit writing HI/LO.
// Takes WIDTH iteration cycles plus one result cycle; flags divide-by-zero without starting.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned AccW = 2 * WIDTH + 1;

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic [CntW-1:0]  count_q, count_d;
  // Upper WIDTH+1 bits: Booth partial product (one guard bit so -2^(W-1) never overflows)
  // or division partial remainder; lower WIDTH bits: multiplier or dividend/quotient.
  logic [AccW-1:0]  acc_q, acc_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_pend_q, dz_pend_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH:0]   m_sext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] quot_signed, rem_signed;

  assign acc_hi = acc_q[AccW-1:WIDTH];
  assign acc_lo = acc_q[WIDTH-1:0];
  assign m_sext = {m_q[WIDTH-1], m_q};

  assign a_mag = a[WIDTH-1] ? ({WIDTH{1'b0}} - a) : a;
  assign b_mag = b[WIDTH-1] ? ({WIDTH{1'b0}} - b) : b;

  always_comb begin
    booth_sum = acc_hi;
    unique case ({acc_lo[0], qm1_q})
      2'b01:   booth_sum = acc_hi + m_sext;
      2'b10:   booth_sum = acc_hi - m_sext;
      default: booth_sum = acc_hi;
    endcase
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .divisor_i (m_q),
    .next_bit_i(acc_lo[WIDTH-1]),
    .rem_o     (rem_next),
    .q_bit_o   (q_bit)
  );

  assign quot_signed = q_neg_q ? ({WIDTH{1'b0}} - acc_lo) : acc_lo;
  assign rem_signed  = r_neg_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH])
                               : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    count_d    = count_q;
    acc_d      = acc_q;
    qm1_d      = qm1_q;
    m_d        = m_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dz_pend_d  = 1'b0;
    div_zero_d = dz_pend_q;

    unique case (state_q)
      StIdle: begin
        if (start_mult) begin
          op_d    = OpMult;
          m_d     = a;
          acc_d   = {{(WIDTH + 1){1'b0}}, b};
          qm1_d   = 1'b0;
          count_d = '0;
          state_d = StRun;
        end else if (start_div) begin
          if (b == '0) begin
            dz_pend_d = 1'b1;
          end else begin
            op_d    = OpDiv;
            m_d     = b_mag;
            acc_d   = {{(WIDTH + 1){1'b0}}, a_mag};
            qm1_d   = 1'b0;
            q_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
            r_neg_d = a[WIDTH-1];
            count_d = '0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        count_d = count_q + 1'b1;
        if (op_q == OpMult) begin
          acc_d = {booth_sum[WIDTH], booth_sum, acc_lo[WIDTH-1:1]};
          qm1_d = acc_lo[0];
        end else begin
          acc_d = {1'b0, rem_next, acc_lo[WIDTH-2:0], q_bit};
        end
        if (count_q == CntW'(WIDTH - 1)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        if (op_q == OpMult) begin
          hi_d = acc_q[2*WIDTH-1:WIDTH];
          lo_d = acc_lo;
        end else begin
          hi_d = rem_signed;
          lo_d = quot_signed;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= OpMult;
      count_q    <= '0;
      acc_q      <= '0;
      qm1_q      <= 1'b0;
      m_q        <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dz_pend_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      qm1_q      <= qm1_d;
      m_q        <= m_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dz_pend_q  <= dz_pend_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multicycle signed multiply/divide unit for the MIPS datapath. It is started by a one-cycle pulse from the control unit and computes a signed 64-bit product (mult) or a signed quotient and remainder (div) over WIDTH iteration cycles. It writes the result to internal HI/LO registers, and the datapath's HI/LO write mux consumes those registers. It also reports divide-by-zero so the control unit can branch to the exception sequence.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start_mult  in  1  one-cycle pulse; begin signed a*b.
- start_div  in  1  one-cycle pulse; begin signed a/b.
- a  in  WIDTH  dividend / multiplicand (register A contents).
- b  in  WIDTH  divisor / multiplier (register B contents).
- hi  out  WIDTH  product high word, or remainder.
- lo  out  WIDTH  product low word, or quotient.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; hi/lo are updated this cycle.
- div_zero  out  1  one-cycle pulse; start_div was issued with b == 0.

## Operation
- States: IDLE, RUN, FIN.
- IDLE: start_mult=1 captures a and b, sets op=MULT and count=0, then goes to RUN.
  - start_div=1 with b≠0 captures |a| and |b| plus the result signs, sets op=DIV, then goes to RUN.
  - start_div=1 with b==0 stays in IDLE, pulses div_zero next cycle, and leaves hi/lo unchanged.
- Simultaneous start_mult and start_div: mult wins and div is dropped.
- Starts received while busy=1 (RUN or FIN) are ignored; there is no queuing.
- RUN, MULT: radix-2 Booth shift-add on a 2*WIDTH+1-bit accumulator, one step per cycle.
- RUN, DIV: restoring division on magnitudes, one quotient bit per cycle.
- RUN advances count each cycle; at count == WIDTH-1 it goes to FIN.
- FIN, MULT: {hi,lo} ← full signed 2*WIDTH product.
- FIN, DIV: lo ← quotient truncated toward zero; hi ← remainder carrying the dividend's sign.
- FIN asserts done=1, then goes to IDLE.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is the natural magnitude-path result and raises no flag.
- hi/lo hold their value until the next FIN or reset. They never show intermediate values.

## Timing
- Reset (clk edge with reset=1): state=IDLE, count=0, hi=0, lo=0, busy=0, done=0, div_zero=0. Internal operand and accumulator registers are cleared.
- Reset mid-operation aborts the operation. hi/lo return to 0, and no done pulse follows.
- Start sampled at edge k:
  - busy=1 after edge k.
  - RUN iterations occur on edges k+1..k+WIDTH.
  - FIN registers the result at edge k+WIDTH+1: done=1 and busy=0 after that edge.
  - Latency is WIDTH+1 cycles, 33 for the default.
- done and div_zero are each exactly one cycle wide. They are never high together.
- div_zero: start_div with b==0 at edge k gives div_zero=1 after edge k+1 and busy=0 throughout.
- A new start is accepted at the edge where done=1 is visible, because the state is already IDLE.

## Structure
- Shared package (mips_pkg): state enum IDLE/RUN/FIN, op enum MULT/DIV, constant WIDTH_DEFAULT=32.
- One combinational sub-module, div_step: takes partial remainder, divisor and next dividend bit; returns the new partial remainder and the quotient bit.
- Booth step, sign correction and FSM stay in mult_div_unit.
- The control unit is expected to drive start_mult/start_div for one cycle, then wait on done or div_zero before using HiLoWrite.

## Test plan
- mult a=7, b=0xFFFFFFFD (-3) → done 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- mult a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0x00000000.
- div a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- div a=100, b=0 → div_zero=1 one cycle after start; busy never 1, done never 1, hi/lo keep prior values.
- mult 5*6 started, start_div pulsed at cycle 10 → ignored; done at cycle 33 with hi=0, lo=30.
- mult 5*6 started, reset at cycle 10 → hi=lo=0, busy=0, no done pulse; a fresh div 9/4 then gives lo=2, hi=1 at cycle 33.
